// File: rtl/tg_prbs_cmd_sequencer_pkg.sv
// Shared types for the PRBS command sequencer: run modes, FSM states,
// the 4 KB page size and an elaboration-time clog2 helper.
package tg_cmd_pkg;

    typedef enum logic [1:0] {
        TG_MODE_PRBS = 2'b00,
        TG_MODE_WR   = 2'b01,
        TG_MODE_RD   = 2'b10,
        TG_MODE_PAIR = 2'b11
    } tg_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } tg_state_e;

    localparam int unsigned TG_PAGE_BYTES = 4096;

    function automatic int unsigned tg_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tg_prbs_cmd_sequencer_if.sv
// Command port bundle between the sequencer and the AXI traffic generator.
// Signals: valid/ready handshake, wr direction, byte addr, blen in beats.
interface tg_prbs_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [8:0]            blen;

    modport master (
        output valid, wr, addr, blen,
        input  ready
    );

    modport slave (
        input  valid, wr, addr, blen,
        output ready
    );
endinterface

// File: rtl/tg_prbs_cmd_sequencer_blen_clamp.sv
// Caps a raw burst length so the burst ends at or before the 4 KB page end.
// Ports: addr_lo (addr[11:0]), raw_blen (beats) in; blen (clamped beats) out.
module tg_blen_4k_clamp
    import tg_cmd_pkg::*;
#(
    parameter int unsigned BYTES_PER_BEAT = 4
) (
    input  logic [11:0] addr_lo,
    input  logic [8:0]  raw_blen,
    output logic [8:0]  blen
);
    localparam int unsigned SH = tg_clog2(BYTES_PER_BEAT);

    // Beats left in the page; addr_lo is beat-aligned so this is exact
    // and never below one.
    logic [12:0] room;

    assign room = (13'(TG_PAGE_BYTES) - {1'b0, addr_lo}) >> SH;

    // When room wins it is <= raw_blen <= 256, so 9 bits hold it.
    assign blen = ({4'b0, raw_blen} < room) ? raw_blen : room[8:0];

endmodule

// File: rtl/tg_prbs_cmd_sequencer.sv
// Consumes three PRBS generators and issues aligned, windowed, 4 KB-safe
// commands over a valid/ready port; counts accepted commands per run.
// Ports: clk_i/rst_n_i, run control (start/stop/mode/total), generator
// seed/step outputs and value inputs, cmd (master), cnt/busy/done status.
module tg_prbs_cmd_sequencer
    import tg_cmd_pkg::*;
#(
    parameter int                    TCQ           = 100,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DWIDTH        = 32,
    parameter int                    SEED_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE     = 'h0000_2000,
    parameter int                    ADDR_WIN_BITS = 16,
    parameter int                    MAX_BLEN      = 16,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [1:0]            mode_i,
    input  logic [CNT_WIDTH-1:0]  cmd_total_i,
    output logic                  prbs_seed_init_o,
    output logic                  prbs_clk_en_o,
    input  logic [SEED_WIDTH-1:0] addr_prbs_i,
    input  logic [SEED_WIDTH-1:0] instr_prbs_i,
    input  logic [SEED_WIDTH-1:0] blen_prbs_i,
    tg_prbs_cmd_sequencer_if.master cmd,
    output logic [CNT_WIDTH-1:0]  cmd_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned BPB = DWIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] WIN_MASK =
        ADDR_WIDTH'((64'd1 << ADDR_WIN_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BPB - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = WIN_MASK & ~BEAT_MASK;
    localparam logic [8:0]            RAW_MASK  = 9'(MAX_BLEN - 1);

    // Register timing is modelled as zero-delay in this RTL.
    localparam int unused_tcq = TCQ;

    tg_state_e             state_q, state_d;
    logic                  valid_q, wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [8:0]            blen_q;
    logic [CNT_WIDTH-1:0]  cnt_q, loads_q, total_q;
    tg_mode_e              mode_q;
    logic                  pair_q;
    logic [ADDR_WIDTH-1:0] pair_addr_q;
    logic [8:0]            pair_blen_q;

    logic                  load, accept, more, pair_rd, dir;
    logic [ADDR_WIDTH-1:0] new_addr;
    logic [8:0]            raw_blen, new_blen;
    logic                  unused_bits;

    assign unused_bits = ^{addr_prbs_i, instr_prbs_i, blen_prbs_i};

    assign new_addr = ADDR_BASE + (ADDR_WIDTH'(addr_prbs_i) & OFF_MASK);
    assign raw_blen = (9'(blen_prbs_i) & RAW_MASK) + 9'd1;

    tg_blen_4k_clamp #(
        .BYTES_PER_BEAT (BPB)
    ) u_clamp (
        .addr_lo  (new_addr[11:0]),
        .raw_blen (raw_blen),
        .blen     (new_blen)
    );

    assign accept  = valid_q & cmd.ready;
    // total_q == 0 means an unbounded run.
    assign more    = (total_q == '0) || (loads_q != total_q);
    assign pair_rd = (mode_q == TG_MODE_PAIR) && pair_q;

    always_comb begin
        dir = 1'b0;
        unique case (mode_q)
            TG_MODE_PRBS: dir = instr_prbs_i[0];
            TG_MODE_WR:   dir = 1'b1;
            TG_MODE_RD:   dir = 1'b0;
            TG_MODE_PAIR: dir = 1'b1;
            default:      dir = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_SEED;
            ST_SEED: state_d = ST_PRIME;
            ST_PRIME: state_d = ST_RUN;
            ST_RUN: begin
                if (stop_i) begin
                    state_d = (valid_q && !cmd.ready) ? ST_DRAIN : ST_DONE;
                end else if (more) begin
                    load = !valid_q || cmd.ready;
                end else if (!valid_q || cmd.ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: if (cmd.ready) state_d = ST_DONE;
            ST_DONE: if (start_i) state_d = ST_SEED;
            default: state_d = ST_IDLE;
        endcase
    end

    // The pair read replays the captured write, so nothing is consumed.
    assign prbs_clk_en_o    = load && !pair_rd;
    assign prbs_seed_init_o = (state_q == ST_SEED);
    assign busy_o           = (state_q == ST_SEED) || (state_q == ST_PRIME) ||
                              (state_q == ST_RUN)  || (state_q == ST_DRAIN);
    assign done_o           = (state_q == ST_DONE);

    assign cmd.valid = valid_q;
    assign cmd.wr    = wr_q;
    assign cmd.addr  = addr_q;
    assign cmd.blen  = blen_q;
    assign cmd_cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            blen_q      <= '0;
            cnt_q       <= '0;
            loads_q     <= '0;
            total_q     <= '0;
            mode_q      <= TG_MODE_PRBS;
            pair_q      <= 1'b0;
            pair_addr_q <= '0;
            pair_blen_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SEED) begin
                cnt_q   <= '0;
                loads_q <= '0;
                pair_q  <= 1'b0;
                mode_q  <= tg_mode_e'(mode_i);
                total_q <= cmd_total_i;
            end
            if (load) begin
                valid_q <= 1'b1;
                loads_q <= loads_q + 1'b1;
                pair_q  <= ~pair_q;
                if (pair_rd) begin
                    wr_q   <= 1'b0;
                    addr_q <= pair_addr_q;
                    blen_q <= pair_blen_q;
                end else begin
                    wr_q        <= dir;
                    addr_q      <= new_addr;
                    blen_q      <= new_blen;
                    pair_addr_q <= new_addr;
                    pair_blen_q <= new_blen;
                end
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_tg_prbs_cmd_sequencer.sv
// Scoreboard bench for tg_prbs_cmd_sequencer with a behavioural model of
// the three PRBS generators driven by the DUT's seed/step outputs.
module tb_tg_prbs_cmd_sequencer;
    import tg_cmd_pkg::*;

    localparam int AW = 32;
    localparam int SW = 32;
    localparam int CW = 16;

    localparam logic [31:0] SEED_A = 32'h1234_5678;
    localparam logic [31:0] SEED_I = 32'h0BAD_F00D;
    localparam logic [31:0] SEED_B = 32'hCAFE_0001;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [8:0]  blen;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] total = '0;
    logic          seed_init, clk_en, busy, done;
    logic [SW-1:0] a_prbs, i_prbs, b_prbs;
    logic [CW-1:0] cnt;

    logic [31:0] ga = '0, gi = '0, gb = '0;
    logic        frc = 1'b0;
    logic [31:0] frc_a = '0, frc_b = '0;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   popped = 0;
    int   en_cnt = 0;

    tg_prbs_cmd_sequencer_if #(.ADDR_WIDTH(AW)) cmd_if ();

    tg_prbs_cmd_sequencer dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .stop_i           (stop),
        .mode_i           (mode),
        .cmd_total_i      (total),
        .prbs_seed_init_o (seed_init),
        .prbs_clk_en_o    (clk_en),
        .addr_prbs_i      (a_prbs),
        .instr_prbs_i     (i_prbs),
        .blen_prbs_i      (b_prbs),
        .cmd              (cmd_if),
        .cmd_cnt_o        (cnt),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    always @(posedge clk) begin
        if (seed_init) begin
            ga <= SEED_A; gi <= SEED_I; gb <= SEED_B;
        end else if (clk_en) begin
            ga <= lfsr(ga); gi <= lfsr(gi); gb <= lfsr(gb);
        end
    end

    assign a_prbs = frc ? frc_a : ga;
    assign b_prbs = frc ? frc_b : gb;
    assign i_prbs = gi;

    // DWIDTH 32 (4 bytes/beat), window 64 KB at 0x2000, MAX_BLEN 16.
    function automatic cmd_t shape(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic wr);
        cmd_t c;
        int   raw, room;
        c.addr = 32'h0000_2000 + (a & 32'h0000_FFFC);
        raw    = int'(b & 32'hF) + 1;
        room   = (4096 - int'(c.addr & 32'hFFF)) / 4;
        c.blen = 9'((raw < room) ? raw : room);
        c.wr   = wr;
        return c;
    endfunction

    task automatic push_exp(input logic [1:0] m, input int n);
        logic [31:0] a, i, b, aa, bb;
        cmd_t c;
        int   k;
        a = SEED_A; i = SEED_I; b = SEED_B;
        k = 0;
        while (k < n) begin
            aa = frc ? frc_a : a;
            bb = frc ? frc_b : b;
            if (m == 2'b11) begin
                c = shape(aa, bb, 1'b1);
                exp_q.push_back(c); k++;
                if (k < n) begin
                    c.wr = 1'b0;
                    exp_q.push_back(c); k++;
                end
            end else begin
                c = shape(aa, bb, (m == 2'b00) ? i[0] : (m == 2'b01));
                exp_q.push_back(c); k++;
            end
            a = lfsr(a); i = lfsr(i); b = lfsr(b);
        end
    endtask

    always @(negedge clk) begin
        if (clk_en) en_cnt++;
        if (rst_n && cmd_if.valid && cmd_if.ready) begin
            popped++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got wr=%0b addr=%h blen=%0d, none expected",
                         cmd_if.wr, cmd_if.addr, cmd_if.blen);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cmd_if.wr, cmd_if.addr, cmd_if.blen} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_cmd: got wr=%0b addr=%h blen=%0d, expected wr=%0b addr=%h blen=%0d",
                             cmd_if.wr, cmd_if.addr, cmd_if.blen,
                             mon_e.wr, mon_e.addr, mon_e.blen);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (cmd_if.valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        cmd_if.ready = 1'b0;
        #12;
        checks++;
        if ({seed_init, clk_en, busy, done, cmd_if.valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 00000",
                     {seed_init, clk_en, busy, done, cmd_if.valid});
        end
        checks++;
        if ({cmd_if.wr, cmd_if.addr, cmd_if.blen, cnt} !== '0) begin
            errors++;
            $display("FAIL reset_fields: wr=%0b addr=%h blen=%0d cnt=%0d, expected all 0",
                     cmd_if.wr, cmd_if.addr, cmd_if.blen, cnt);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, seed_init} !== 3'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/done/seed=%b, expected 000",
                     {busy, done, seed_init});
        end
    endtask

    task automatic test_basic();
        int  seed_at, en_first, v_first, seed_n, acc_n, acc_first, acc_last;
        seed_at = -1; en_first = -1; v_first = -1; seed_n = 0;
        acc_n = 0; acc_first = -1; acc_last = -1;
        mode = 2'b01; total = 16'd4; cmd_if.ready = 1'b1;
        exp_q.delete(); push_exp(2'b01, 4);
        en_cnt = 0;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (seed_init) begin
                seed_n++;
                if (seed_at < 0) seed_at = c;
            end
            if (clk_en && en_first < 0) en_first = c;
            if (cmd_if.valid && v_first < 0) v_first = c;
            if (cmd_if.valid && cmd_if.ready) begin
                acc_n++;
                if (acc_first < 0) acc_first = c;
                acc_last = c;
            end
            if (done) break;
        end
        checks++;
        if (seed_n != 1) begin
            errors++;
            $display("FAIL basic_seed_len: got %0d cycles, expected 1", seed_n);
        end
        checks++;
        if (en_first - seed_at != 2) begin
            errors++;
            $display("FAIL basic_first_en: got %0d cycles after seed, expected 2",
                     en_first - seed_at);
        end
        checks++;
        if (v_first - seed_at != 3) begin
            errors++;
            $display("FAIL basic_first_valid: got %0d cycles after seed, expected 3",
                     v_first - seed_at);
        end
        checks++;
        if (acc_n != 4 || acc_last - acc_first != 3) begin
            errors++;
            $display("FAIL basic_b2b: got %0d accepts over %0d cycles, expected 4 over 4",
                     acc_n, acc_last - acc_first + 1);
        end
        checks++;
        if (en_cnt != 4) begin
            errors++;
            $display("FAIL basic_clk_en: got %0d pulses, expected 4", en_cnt);
        end
        checks++;
        if (done !== 1'b1 || cnt !== 16'd4) begin
            errors++;
            $display("FAIL basic_done: done=%0b cnt=%0d, expected done=1 cnt=4",
                     done, cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: %0d expected commands left, expected 0",
                     exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        mode = 2'b00; total = 16'd3; cmd_if.ready = 1'b0;
        exp_q.delete(); push_exp(2'b00, 3);
        pulse_start();
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid: valid=0 after 20 cycles, expected 1");
        end
        en_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0 ||
                {cmd_if.valid, cmd_if.wr, cmd_if.addr, cmd_if.blen} !==
                {1'b1, exp_q[0]}) begin
                errors++;
                $display("FAIL bp_stable: cycle %0d got v=%0b wr=%0b addr=%h blen=%0d",
                         c, cmd_if.valid, cmd_if.wr, cmd_if.addr, cmd_if.blen);
            end
        end
        checks++;
        if (en_cnt != 0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_stall: clk_en=%0d cnt=%0d, expected 0 and 0",
                     en_cnt, cnt);
        end
        @(posedge clk); #1 cmd_if.ready = 1'b1;
        wait_done(40, ok);
        checks++;
        if (!ok || cnt !== 16'd3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: done=%0b cnt=%0d left=%0d, expected 1/3/0",
                     done, cnt, exp_q.size());
        end
    endtask

    task automatic test_clamp();
        logic [31:0] t_a[3]    = '{32'h0000_0FF8, 32'h0000_0000, 32'h0000_1FE3};
        logic [31:0] t_addr[3] = '{32'h0000_2FF8, 32'h0000_2000, 32'h0000_3FE0};
        logic [8:0]  t_blen[3] = '{9'd2, 9'd16, 9'd8};
        logic [1:0]  t_mode[3] = '{2'b01, 2'b01, 2'b10};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            frc = 1'b1; frc_a = t_a[k]; frc_b = 32'h0000_000F;
            mode = t_mode[k]; total = 16'd1; cmd_if.ready = 1'b0;
            exp_q.delete(); push_exp(t_mode[k], 1);
            pulse_start();
            wait_valid(20, ok);
            checks++;
            if (!ok || cmd_if.addr !== t_addr[k] || cmd_if.blen !== t_blen[k] ||
                cmd_if.wr !== (t_mode[k] == 2'b01)) begin
                errors++;
                $display("FAIL clamp_%0d: got addr=%h blen=%0d wr=%0b, expected addr=%h blen=%0d",
                         k, cmd_if.addr, cmd_if.blen, cmd_if.wr, t_addr[k], t_blen[k]);
            end
            @(posedge clk); #1 cmd_if.ready = 1'b1;
            wait_done(20, ok);
            checks++;
            if (!ok || cnt !== 16'd1 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL clamp_done_%0d: done=%0b cnt=%0d, expected 1/1",
                         k, done, cnt);
            end
        end
        frc = 1'b0;
    endtask

    task automatic test_pair();
        bit ok;
        mode = 2'b11; total = 16'd4; cmd_if.ready = 1'b1;
        exp_q.delete(); push_exp(2'b11, 4);
        en_cnt = 0;
        pulse_start();
        wait_done(40, ok);
        checks++;
        if (!ok || cnt !== 16'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pair_done: done=%0b cnt=%0d left=%0d, expected 1/4/0",
                     done, cnt, exp_q.size());
        end
        checks++;
        if (en_cnt != 2) begin
            errors++;
            $display("FAIL pair_clk_en: got %0d pulses, expected 2", en_cnt);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int vcnt;
        mode = 2'b01; total = 16'd0; cmd_if.ready = 1'b0;
        exp_q.delete(); push_exp(2'b01, 1);
        pulse_start();
        wait_valid(20, ok);
        @(posedge clk); #1 stop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({cmd_if.valid, busy, done} !== 3'b110) begin
                errors++;
                $display("FAIL abort_drain: valid/busy/done=%b, expected 110",
                         {cmd_if.valid, busy, done});
            end
        end
        @(posedge clk); #1 cmd_if.ready = 1'b1;
        wait_done(10, ok);
        checks++;
        if (!ok || cnt !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_done: done=%0b cnt=%0d left=%0d, expected 1/1/0",
                     done, cnt, exp_q.size());
        end
        stop = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cmd_if.valid) vcnt++;
        end
        checks++;
        if (vcnt != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: %0d valid cycles done=%0b, expected 0 and 1",
                     vcnt, done);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int seed_n;
        seed_n = 0;
        mode = 2'b01; total = 16'd0; cmd_if.ready = 1'b1;
        exp_q.delete(); push_exp(2'b01, 40);
        popped = 0;
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (seed_init) seed_n++;
        end
        @(posedge clk); #1 stop = 1'b1;
        wait_done(10, ok);
        stop = 1'b0;
        checks++;
        if (seed_n != 1) begin
            errors++;
            $display("FAIL restart_seed: got %0d seed cycles, expected 1", seed_n);
        end
        checks++;
        if (!ok || popped < 16 || cnt !== 16'(popped)) begin
            errors++;
            $display("FAIL restart_unbounded: done=%0b cnt=%0d accepts=%0d, expected >=16 and equal",
                     done, cnt, popped);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midrun();
        mode = 2'b01; total = 16'd0; cmd_if.ready = 1'b1;
        exp_q.delete(); push_exp(2'b01, 40);
        pulse_start();
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seed_init, clk_en, busy, done, cmd_if.valid} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_ctl: got %b, expected 00000",
                     {seed_init, clk_en, busy, done, cmd_if.valid});
        end
        checks++;
        if ({cmd_if.wr, cmd_if.addr, cmd_if.blen, cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_fields: wr=%0b addr=%h blen=%0d cnt=%0d, expected all 0",
                     cmd_if.wr, cmd_if.addr, cmd_if.blen, cnt);
        end
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp();
        test_pair();
        test_abort();
        test_restart();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
